// File: rtl/note_player.sv
// Triangle-wave tone source: plays one note (phase step + duration in beats),
// emitting a signed 16-bit sample per codec request and a pulse at note end.
module note_player #(
    parameter int PHASE_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_new_note,
    input  logic [PHASE_W-1:0]  step_size,
    input  logic [5:0]          duration_in,
    input  logic                play_enable,
    input  logic                beat,
    input  logic                generate_next_sample,
    output logic signed [15:0]  sample_out,
    output logic                new_sample_ready,
    output logic [5:0]          note_duration,
    output logic                done_with_note,
    output logic                busy
);

    typedef enum logic {IDLE, PLAYING} state_t;

    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] step_q;
    logic [5:0]         beat_cnt_q;
    logic signed [15:0] sample_d;

    // Quadrant-folded triangle: s ramps 0..0x7FFE within each quarter period.
    function automatic logic signed [15:0] tri_wave(input logic [15:0] u);
        logic [15:0] s;
        logic [15:0] w;
        s = {1'b0, u[13:0], 1'b0};
        case (u[15:14])
            2'd0:    w = s;
            2'd1:    w = 16'h7FFF - s;
            2'd2:    w = 16'd0 - s;
            default: w = s - 16'h7FFF;
        endcase
        return signed'(w);
    endfunction

    always_comb begin
        sample_d = tri_wave(phase_q[PHASE_W-1 -: 16]);
    end

    // NOTE: all state and outputs update with <= so every branch reads the
    // pre-edge values (e.g. the sample uses the phase before its increment).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            phase_q          <= '0;
            step_q           <= '0;
            beat_cnt_q       <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            note_duration    <= '0;
            done_with_note   <= 1'b0;
            busy             <= 1'b0;
        end else begin
            new_sample_ready <= 1'b0;
            done_with_note   <= 1'b0;
            case (state_q)
                IDLE: begin
                    sample_out <= '0;
                    if (load_new_note) begin
                        state_q       <= PLAYING;
                        busy          <= 1'b1;
                        step_q        <= step_size;
                        note_duration <= duration_in;
                        phase_q       <= '0;
                        beat_cnt_q    <= '0;
                    end
                end
                PLAYING: begin
                    if (note_duration == 6'd0) begin
                        state_q        <= IDLE;
                        busy           <= 1'b0;
                        done_with_note <= 1'b1;
                    end else if (play_enable) begin
                        if (generate_next_sample) begin
                            phase_q          <= phase_q + step_q;
                            sample_out       <= sample_d;
                            new_sample_ready <= 1'b1;
                        end
                        if (beat) begin
                            beat_cnt_q <= beat_cnt_q + 6'd1;
                            if (beat_cnt_q == note_duration - 6'd1) begin
                                state_q        <= IDLE;
                                busy           <= 1'b0;
                                done_with_note <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
